mux_nto1_sync: RTL and testbench



---
 rtl/puf_mux_pkg.sv | 11 +
 rtl/sync_chain.sv | 30 +++
 rtl/mux_nto1_sync.sv | 120 ++++++++++++
 tb/tb_mux_nto1_sync.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/puf_mux_pkg.sv
// Shared types and elaboration-time checks for the PUF cell selector family.
package puf_mux_pkg;

  typedef enum logic {SETTLE, READY} mux_state_e;

  // The blanking window must outlast the synchroniser so no stale sample escapes.
  function automatic bit settle_cyc_ok(input int settle_cyc, input int sync_stages);
    return settle_cyc >= sync_stages + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Flop synchroniser for one asynchronous bit, with a synchronous clear that
// flushes every stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg_q;
  logic [STAGES-1:0] stg_d;

  always_comb begin
    stg_d = clr ? '0 : {stg_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign q = stg_q[STAGES-1];

endmodule

// File: rtl/mux_nto1_sync.sv
// N:1 PUF cell selector: registered select with valid/ready handshake,
// range rejection, post-switch blanking and a synchronised output.
module mux_nto1_sync
  import puf_mux_pkg::*;
#(
  parameter int N_IN        = 16,
  parameter int SEL_W       = $clog2(N_IN),
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic [SEL_W-1:0] sel_cur,
  output logic             out,
  output logic             out_valid,
  output logic             err_range
);

  localparam int               CNT_W    = $clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_IN);

  if (!settle_cyc_ok(SETTLE_CYC, SYNC_STAGES)) begin : g_bad_settle
    $error("SETTLE_CYC must be at least SYNC_STAGES+1");
  end

  mux_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             in_range;
  logic             accept;
  logic             raw;
  logic             sync_out;

  always_comb begin
    in_range = ({1'b0, req_sel} < N_LIM);
    accept   = (state_q == READY) && req_valid && in_range;
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    case (state_q)
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = READY;
          valid_d = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READY: begin
        // Out-of-range requests are consumed but leave the routing untouched.
        if (req_valid) begin
          if (in_range) begin
            sel_d   = req_sel;
            state_d = SETTLE;
            cnt_d   = CNT_INIT;
            valid_d = 1'b0;
            ready_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= CNT_INIT;
      sel_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    raw = 1'b0;
    if ({1'b0, sel_q} < N_LIM) begin
      raw = in[sel_q];
    end
  end

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .d    (raw),
    .q    (sync_out)
  );

  assign out       = sync_out & valid_q;
  assign out_valid = valid_q;
  assign req_ready = ready_q;
  assign sel_cur   = sel_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_mux_nto1_sync.sv
// Bench for mux_nto1_sync: a 16-input and a 12-input instance checked every
// cycle against an edges-since-selection model, plus literal scenario checks.
module tb_mux_nto1_sync;

  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in0 = '0;
  logic [11:0] in1 = '0;
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic [3:0]  rs0 = '0, rs1 = '0;
  logic        rdy0, rdy1, o0, o1, ov0, ov1, er0, er1;
  logic [3:0]  sc0, sc1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_nto1_sync #(.N_IN(16), .SYNC_STAGES(2), .SETTLE_CYC(SETTLE)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .req_valid(rv0), .req_sel(rs0),
    .req_ready(rdy0), .sel_cur(sc0), .out(o0), .out_valid(ov0), .err_range(er0)
  );

  mux_nto1_sync #(.N_IN(12), .SYNC_STAGES(2), .SETTLE_CYC(SETTLE)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .req_valid(rv1), .req_sel(rs1),
    .req_ready(rdy1), .sel_cur(sc1), .out(o1), .out_valid(ov1), .err_range(er1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Input channels: random noise, except channel 5 of instance 0 toggles every 6 clocks.
  int  tcnt = 0;
  logic tog = 1'b0;
  always @(negedge clk) begin
    tcnt++;
    if (tcnt % 6 == 0) tog = ~tog;
    in0 = 16'($urandom);
    in0[5] = tog;
    in1 = 12'($urandom);
  end

  // Model: edges since the last reset/acceptance decide validity; out is the
  // routed channel sampled one edge earlier, masked by validity.
  int          n_m[2]   = '{0, 0};
  int          sel_m[2] = '{0, 0};
  bit          err_m[2] = '{0, 0};
  bit          rh0[2]   = '{0, 0};
  bit          rh1[2]   = '{0, 0};
  logic [15:0] iv[2];
  bit          vv[2];
  int          ss[2];

  always @(posedge clk) begin
    iv[0] = in0;
    iv[1] = {4'b0, in1};
    vv[0] = rv0;
    vv[1] = rv1;
    ss[0] = int'(rs0);
    ss[1] = int'(rs1);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        n_m[i] = 0; sel_m[i] = 0; err_m[i] = 0; rh0[i] = 0; rh1[i] = 0;
      end else begin
        rh1[i] = rh0[i];
        rh0[i] = iv[i][sel_m[i]];
        err_m[i] = 0;
        if (n_m[i] >= SETTLE && vv[i]) begin
          if (ss[i] < ((i == 0) ? 16 : 12)) begin
            sel_m[i] = ss[i];
            n_m[i] = 0;
          end else begin
            err_m[i] = 1;
          end
        end else if (n_m[i] < SETTLE) begin
          n_m[i]++;
        end
      end
    end
    #1;
    chk("m0_sel", 32'(sc0), 32'(sel_m[0]));
    chk("m0_valid", 32'(ov0), 32'(n_m[0] >= SETTLE));
    chk("m0_ready", 32'(rdy0), 32'(n_m[0] >= SETTLE));
    chk("m0_err", 32'(er0), 32'(err_m[0]));
    chk("m0_out", 32'(o0), 32'((n_m[0] >= SETTLE) && rh1[0]));
    chk("m1_sel", 32'(sc1), 32'(sel_m[1]));
    chk("m1_valid", 32'(ov1), 32'(n_m[1] >= SETTLE));
    chk("m1_ready", 32'(rdy1), 32'(n_m[1] >= SETTLE));
    chk("m1_err", 32'(er1), 32'(err_m[1]));
    chk("m1_out", 32'(o1), 32'((n_m[1] >= SETTLE) && rh1[1]));
  end

  // Called at a negedge; holds the request until an edge with ready high, returns at the next negedge.
  task automatic req(input int i, input logic [3:0] s);
    bit done = 0;
    if (i == 0) begin rs0 = s; rv0 = 1'b1; end
    else        begin rs1 = s; rv1 = 1'b1; end
    for (int k = 0; k < 100 && !done; k++) begin
      if ((i == 0) ? rdy0 : rdy1) done = 1;
      @(negedge clk);
    end
    rv0 = 1'b0;
    rv1 = 1'b0;
    if (!done) chk("req_accept", 32'((i == 0) ? rdy0 : rdy1), 32'd1);
  endtask

  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic settle_after_release();
    for (int e = 1; e <= SETTLE; e++) begin
      @(posedge clk);
      #2;
      chk("rst_ov0", 32'(ov0), 32'(e == SETTLE));
      chk("rst_rdy0", 32'(rdy0), 32'(e == SETTLE));
      chk("rst_sel0", 32'(sc0), 32'd0);
      chk("rst_ov1", 32'(ov1), 32'(e == SETTLE));
    end
    @(negedge clk);
  endtask

  initial begin
    wait_neg(3);
    rst_n = 1'b1;
    settle_after_release();

    // Route channel 5, then queue channel 9 while still blanking.
    req(0, 4'd5);
    chk("sel5_ov_low", 32'(ov0), 32'd0);
    chk("settle_rdy_low", 32'(rdy0), 32'd0);
    req(0, 4'd9);
    chk("sel9_ov_low", 32'(ov0), 32'd0);
    wait_neg(SETTLE - 1);
    chk("sel9_ov_still_low", 32'(ov0), 32'd0);
    wait_neg(1);
    chk("sel9_ov_high", 32'(ov0), 32'd1);
    chk("sel9_sel", 32'(sc0), 32'd9);

    // Channel 5 tracked for a while.
    req(0, 4'd5);
    wait_neg(SETTLE + 20);
    chk("sel5_sel", 32'(sc0), 32'd5);

    // Same-channel flush re-runs the blanking window.
    req(0, 4'd3);
    req(0, 4'd3);
    chk("flush_ov_low", 32'(ov0), 32'd0);
    wait_neg(SETTLE - 1);
    chk("flush_ov_still_low", 32'(ov0), 32'd0);
    wait_neg(1);
    chk("flush_ov_high", 32'(ov0), 32'd1);

    // Out-of-range on the 12-input instance.
    req(1, 4'd13);
    chk("oor_err", 32'(er1), 32'd1);
    chk("oor_sel", 32'(sc1), 32'd0);
    chk("oor_ov", 32'(ov1), 32'd1);
    @(posedge clk);
    #2;
    chk("oor_err_clear", 32'(er1), 32'd0);
    @(negedge clk);
    req(1, 4'd11);
    chk("sel11_err", 32'(er1), 32'd0);
    wait_neg(SETTLE);
    chk("sel11_sel", 32'(sc1), 32'd11);
    chk("sel11_ov", 32'(ov1), 32'd1);

    // Randomised requests on both instances.
    for (int it = 0; it < 150; it++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      req(inst, 4'($urandom_range(0, 15)));
      wait_neg(int'($urandom_range(0, 12)));
    end
    wait_neg(SETTLE + 2);

    // Asynchronous reset between edges in the middle of a blanking window.
    req(0, 4'd7);
    wait_neg(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov0", 32'(ov0), 32'd0);
    chk("arst_rdy0", 32'(rdy0), 32'd0);
    chk("arst_sel0", 32'(sc0), 32'd0);
    chk("arst_out0", 32'(o0), 32'd0);
    chk("arst_ov1", 32'(ov1), 32'd0);
    chk("arst_err1", 32'(er1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle_after_release();
    wait_neg(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
